// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the instruction fetch queue
package fetch_pkg;

    localparam logic [6:0]  OP_JAL        = 7'b1101111;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN,
        FULL,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sign-extended J-type immediate (imm[20|10:1|11|19:12], bit 0 implied zero)
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc, instr} FIFO with flush and zero-latency head read
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         full,
    output logic         empty,
    output logic [31:0]  head_instr,
    output logic [31:0]  head_pc
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [31:0]     last_pc;
    fetch_entry_t    head;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer and last-popped-PC bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            last_pc <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                last_pc <= head.pc;
            end
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Head presentation: NOP and the last consumed PC when nothing is queued
    always_comb begin
        head_instr = NOP_INSTR;
        head_pc    = last_pc;
        if (!empty) begin
            head_instr = head.instr;
            head_pc    = head.pc;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end (I-bus driver, FIFO, decode head); optional FETCH_JAL_EARLY_EN
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iready_n,
    input  logic [31:0] idata,
    output logic [31:0] iaddr,
    input  logic        keep,
    input  logic        nop,
    input  logic        branch_PC_contral,
    input  logic [31:0] branch_PC,
    output logic [31:0] Instraction_pype,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic        inst_valid,
    output logic [4:0]  fornop_register1_pype,
    output logic [4:0]  fornop_register2_pype
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_nxt;
    logic         full;
    logic         empty;
    logic         flush;
    logic         pop;
    logic         push;
    logic         jal_taken;
    logic [31:0]  seq_pc;
    logic [31:0]  head_instr;
    logic [31:0]  head_pc;
    fetch_entry_t wr_entry;

    // A redirect or squash cancels both ends of the queue for this cycle
    assign flush    = branch_PC_contral || nop;
    assign pop      = !empty && !keep && !flush;
    assign push     = (state == RUN) && !iready_n && (!full || pop) && !flush;
    assign wr_entry = '{pc: fetch_pc, instr: idata};

`ifdef FETCH_JAL_EARLY_EN
    assign jal_taken = push && (idata[6:0] == OP_JAL);
    assign seq_pc    = jal_taken ? (fetch_pc + j_imm(idata)) : (fetch_pc + 32'd4);
`else
    assign jal_taken = 1'b0;
    assign seq_pc    = fetch_pc + 32'd4;
`endif

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_entry   (wr_entry),
        .full       (full),
        .empty      (empty),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    // State and fetch PC registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Next state / next fetch PC; redirect outranks squash, which outranks normal flow
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (branch_PC_contral) begin
            fetch_pc_nxt = branch_PC & ~32'h3;
            state_nxt    = DISCARD;
        end else if (!nop) begin
            case (state)
                RUN: begin
                    if (push) begin
                        fetch_pc_nxt = seq_pc;
                    end
                    if (jal_taken) begin
                        state_nxt = DISCARD;
                    end else if (full && !pop) begin
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (!(full && !pop)) begin
                        state_nxt = RUN;
                    end
                end
                DISCARD: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign iaddr                 = fetch_pc;
    assign inst_valid            = !empty;
    assign Instraction_pype      = head_instr;
    assign PC_pype0              = head_pc;
    assign PCp4_pype0            = head_pc + 32'd4;
    assign fornop_register1_pype = head_instr[19:15];
    assign fornop_register2_pype = head_instr[24:20];

endmodule
